// File: rtl/lc4_pkg.sv
// Shared LC4 definitions: register file geometry and NZP condition-code
// encodings. Imported by lc4_reg and lc4_regfile.
package lc4_pkg;
    localparam int LC4_REG_W    = 16;  // width of every GPR and data port
    localparam int LC4_NUM_REGS = 8;   // R0..R7

    // Condition codes are one-hot {N,Z,P}; 3'b000 only appears out of reset.
    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;
endpackage

// File: rtl/lc4_reg.sv
// lc4_reg: single n-bit register with synchronous active-high reset and a
// two-level write enable (global gwe AND local we).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset to RESET_VAL, independent of gwe/we
//   gwe  - global write enable
//   we   - local write enable
//   d    - next value
//   q    - registered value
module lc4_reg #(
    parameter int           n         = 16,
    parameter logic [n-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         gwe,
    input  logic         we,
    input  logic [n-1:0] d,
    output logic [n-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= RESET_VAL;
        else if (gwe && we)
            q <= d;
    end

endmodule

// File: rtl/lc4_regfile.sv
// lc4_regfile: LC4 general-purpose register file (R0..R7) with two
// combinational read ports, one write port and the NZP condition-code
// register.
// Ports:
//   clk, rst   - clock; synchronous active-high reset clears all GPRs and NZP
//   gwe        - global write enable; nothing but reset changes state when low
//   i_rs/o_rs_data - read port A select / data (combinational)
//   i_rt/o_rt_data - read port B select / data (combinational)
//   i_rd, i_wdata, i_rd_we - write port select / data / request
//   i_nzp_we   - load o_nzp from the sign of i_wdata
//   o_nzp      - registered {N,Z,P}
// Build option: define LC4_REGFILE_BYPASS_EN to forward the same-cycle write
// data to a read port whose select matches i_rd. Without it, reads return
// the pre-write contents. NZP is never forwarded.
module lc4_regfile
    import lc4_pkg::*;
#(
    parameter int n        = LC4_REG_W,
    parameter int NUM_REGS = LC4_NUM_REGS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         gwe,
    input  logic [2:0]   i_rs,
    output logic [n-1:0] o_rs_data,
    input  logic [2:0]   i_rt,
    output logic [n-1:0] o_rt_data,
    input  logic [2:0]   i_rd,
    input  logic [n-1:0] i_wdata,
    input  logic         i_rd_we,
    input  logic         i_nzp_we,
    output logic [2:0]   o_nzp
);

    logic [NUM_REGS-1:0][n-1:0] regs;
    logic [NUM_REGS-1:0]        reg_we;
    logic [2:0]                 nzp_next;

    // One register per GPR; the write decoder picks exactly one of them.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign reg_we[i] = i_rd_we && (i_rd == 3'(i));

        lc4_reg #(
            .n        (n),
            .RESET_VAL('0)
        ) u_reg (
            .clk(clk),
            .rst(rst),
            .gwe(gwe),
            .we (reg_we[i]),
            .d  (i_wdata),
            .q  (regs[i])
        );
    end

    // Sign of the write data, treated as two's complement.
    always_comb begin
        nzp_next = NZP_P;
        if (i_wdata[n-1])
            nzp_next = NZP_N;
        else if (i_wdata == '0)
            nzp_next = NZP_Z;
    end

    lc4_reg #(
        .n        (3),
        .RESET_VAL(3'b000)
    ) u_nzp (
        .clk(clk),
        .rst(rst),
        .gwe(gwe),
        .we (i_nzp_we),
        .d  (nzp_next),
        .q  (o_nzp)
    );

`ifdef LC4_REGFILE_BYPASS_EN
    // Forward only a write that will actually commit this edge.
    logic wr_fwd;
    assign wr_fwd    = gwe && i_rd_we && !rst;
    assign o_rs_data = (wr_fwd && (i_rs == i_rd)) ? i_wdata : regs[i_rs];
    assign o_rt_data = (wr_fwd && (i_rt == i_rd)) ? i_wdata : regs[i_rt];
`else
    assign o_rs_data = regs[i_rs];
    assign o_rt_data = regs[i_rt];
`endif

endmodule

// File: tb/tb_lc4_regfile.sv
module tb_lc4_regfile;
    logic        clk = 1'b0;
    logic        rst, gwe, i_rd_we, i_nzp_we;
    logic [2:0]  i_rs, i_rt, i_rd;
    logic [15:0] i_wdata, o_rs_data, o_rt_data;
    logic [2:0]  o_nzp;

    lc4_regfile dut (
        .clk(clk), .rst(rst), .gwe(gwe),
        .i_rs(i_rs), .o_rs_data(o_rs_data),
        .i_rt(i_rt), .o_rt_data(o_rt_data),
        .i_rd(i_rd), .i_wdata(i_wdata), .i_rd_we(i_rd_we),
        .i_nzp_we(i_nzp_we), .o_nzp(o_nzp)
    );

    always #5 clk = ~clk;

`ifdef LC4_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Scoreboard entry: which output, what value, and a tag for reporting.
    typedef struct {
        string       tag;
        int          port;   // 0 = rs, 1 = rt, 2 = nzp
        logic [15:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] mdl[8];
    logic [2:0]  mdl_nzp;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int port, input logic [15:0] exp);
        exp_t e;
        e.tag = tag; e.port = port; e.exp = exp;
        sb.push_back(e);
    endtask

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if (v[15])       return 3'b100;
        else if (v == 0) return 3'b010;
        else             return 3'b001;
    endfunction

    task automatic drive(input logic r, input logic g, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [2:0] rd,
                         input logic [15:0] wd, input logic we, input logic nwe);
        rst = r; gwe = g; i_rs = rs; i_rt = rt; i_rd = rd;
        i_wdata = wd; i_rd_we = we; i_nzp_we = nwe;
    endtask

    // Sample mid-cycle, drain the scoreboard, then clock and update the model.
    task automatic step();
        exp_t e;
        #3;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.port)
                0:       chk(e.tag, o_rs_data, e.exp);
                1:       chk(e.tag, o_rt_data, e.exp);
                default: chk(e.tag, {13'd0, o_nzp}, e.exp);
            endcase
        end
        if (rst) begin
            for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
            mdl_nzp = 3'b000;
        end else if (gwe) begin
            if (i_rd_we)  mdl[i_rd] = i_wdata;
            if (i_nzp_we) mdl_nzp   = nzp_of(i_wdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [2:0] rd, input logic [15:0] wd, input logic nwe);
        drive(1'b0, 1'b1, 3'd0, 3'd0, rd, wd, 1'b1, nwe);
        step();
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 3'(i), 3'(7 - i), 3'd0, 16'h0, 1'b0, 1'b0);
            push(tag, 0, 16'h0000);
            push(tag, 1, 16'h0000);
            if (i == 0) push({tag, "_nzp"}, 2, 16'h0000);
            step();
        end
    endtask

    initial begin
        logic [15:0] wd;
        logic [2:0]  rs, rt, rd;
        logic        g, we, nwe, r;

        drive(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        // Second reset cycle: registers already cleared by the first edge.
        push("in_reset_rs", 0, 16'h0000);
        push("in_reset_rt", 1, 16'h0000);
        push("in_reset_nzp", 2, 16'h0000);
        step();
        check_all_zero("post_reset");

        // Arbitrary writes, then a one-cycle reset clears everything.
        for (int i = 0; i < 8; i++) wr(3'(i), 16'hA000 + 16'(i), 1'b1);
        drive(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0);
        step();
        check_all_zero("reset_clear");

        // Write R3, read it on both ports; R2 untouched.
        wr(3'd3, 16'hBEEF, 1'b0);
        drive(1'b0, 1'b0, 3'd3, 3'd3, 3'd0, 16'h0, 1'b0, 1'b0);
        push("r3_rs", 0, 16'hBEEF);
        push("r3_rt", 1, 16'hBEEF);
        step();
        drive(1'b0, 1'b0, 3'd2, 3'd3, 3'd0, 16'h0, 1'b0, 1'b0);
        push("r2_zero", 0, 16'h0000);
        step();

        // gwe gating: set NZP to N first so a leaked update would be visible.
        wr(3'd6, 16'h8000, 1'b1);
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd5, 16'h1234, 1'b1, 1'b1);
        step();
        drive(1'b0, 1'b0, 3'd5, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0);
        push("gwe0_r5", 0, 16'h0000);
        push("gwe0_nzp", 2, 16'h0004);
        step();

        // NZP from 8000 / 0000 / 0001, each visible one cycle later.
        drive(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 16'h8000, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1);
        push("nzp_n", 2, 16'h0004);
        step();
        drive(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 16'h0001, 1'b0, 1'b1);
        push("nzp_z", 2, 16'h0002);
        step();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0);
        push("nzp_p", 2, 16'h0001);
        step();

        // Same-cycle read of a register being written.
        wr(3'd4, 16'h0001, 1'b0);
        drive(1'b0, 1'b1, 3'd4, 3'd4, 3'd4, 16'h00FF, 1'b1, 1'b1);
        push("byp_rs", 0, BYP ? 16'h00FF : 16'h0001);
        push("byp_rt", 1, BYP ? 16'h00FF : 16'h0001);
        push("byp_nzp", 2, 16'h0001);   // still the registered value
        step();
        drive(1'b0, 1'b0, 3'd4, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0);
        push("byp_next", 0, 16'h00FF);
        step();

        // Reset priority over a same-cycle write and NZP update.
        wr(3'd0, 16'h7777, 1'b1);
        drive(1'b1, 1'b1, 3'd1, 3'd0, 3'd1, 16'h5555, 1'b1, 1'b1);
        step();
        drive(1'b0, 1'b0, 3'd1, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0);
        push("rstpri_r1", 0, 16'h0000);
        push("rstpri_r0", 1, 16'h0000);
        push("rstpri_nzp", 2, 16'h0000);
        step();

        // R0 is an ordinary register.
        wr(3'd0, 16'hC0DE, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0);
        push("r0_rw", 0, 16'hC0DE);
        step();

        // Random traffic against the reference model.
        for (int k = 0; k < 200; k++) begin
            rs = 3'($urandom_range(0, 7));
            rt = 3'($urandom_range(0, 7));
            rd = 3'($urandom_range(0, 7));
            wd = 16'($urandom);
            if ((k % 5) == 0) wd = 16'h0;
            g   = ($urandom_range(0, 3) != 0);
            we  = ($urandom_range(0, 1) != 0);
            nwe = ($urandom_range(0, 1) != 0);
            r   = ($urandom_range(0, 49) == 0);
            drive(r, g, rs, rt, rd, wd, we, nwe);
            push("rnd_rs", 0, (BYP && g && we && !r && rs == rd) ? wd : mdl[rs]);
            push("rnd_rt", 1, (BYP && g && we && !r && rt == rd) ? wd : mdl[rt]);
            push("rnd_nzp", 2, {13'd0, mdl_nzp});
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lc4_regfile.md
LC4_REGFILE -- requirements
Module: lc4_regfile

Interface
REQ-001 Parameter: n, 16, data width of every register and data port.
REQ-002 Parameter: NUM_REGS, 8, number of general-purpose registers R0..R7.
REQ-003 Clock is clk; reset is rst; one clock; rst is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 gwe  input  1  global write enable; no state changes when low.
REQ-007 i_rs  input  3  read-port A register select.
REQ-008 o_rs_data  output  n  read-port A data, feeds ALU i_r1data.
REQ-009 i_rt  input  3  read-port B register select.
REQ-010 o_rt_data  output  n  read-port B data, feeds ALU i_r2data.
REQ-011 i_rd  input  3  write-port register select.
REQ-012 i_wdata  input  n  write data, driven by ALU o_result or memory data.
REQ-013 i_rd_we  input  1  register write request.
REQ-014 i_nzp_we  input  1  NZP flag update request.
REQ-015 o_nzp  output  3  registered condition codes {N,Z,P}.

Function
REQ-016 Reads are combinational. o_rs_data = R[i_rs] and o_rt_data = R[i_rt], with zero-cycle latency.
REQ-017 On a rising clk edge with gwe=1 and i_rd_we=1, R[i_rd] is loaded with i_wdata. The new value is visible on the read ports from the next cycle.
REQ-018 When gwe=0 or i_rd_we=0, no register changes.
REQ-019 On a rising edge with gwe=1 and i_nzp_we=1, o_nzp is loaded from signed i_wdata: 3'b100 if negative, 3'b010 if zero, 3'b001 if positive.
REQ-020 i_nzp_we operates independently of i_rd_we. Both may be asserted in the same cycle and then both update from the same i_wdata.
REQ-021 R0 is an ordinary writable register; there is no hardwired zero.
REQ-022 Both read ports may select the same register, including i_rd, in the same cycle. Both return identical data.
REQ-023 There is one write port, so no write-write conflict exists.
REQ-024 An out-of-range select cannot occur, because the 3-bit selects equal NUM_REGS=8.

Reset
REQ-025 On a rising edge with rst=1, R0..R7 are cleared to 16'h0000 and o_nzp is cleared to 3'b000. This is independent of gwe.
REQ-026 rst has priority over any same-cycle write or NZP update. That write is discarded.
REQ-027 During reset, and in the cycle after it, o_rs_data = o_rt_data = 16'h0000.

Configuration
REQ-028 Macro LC4_REGFILE_BYPASS_EN controls write-to-read forwarding.
REQ-029 With LC4_REGFILE_BYPASS_EN defined: when gwe=1, i_rd_we=1, rst=0 and a read select equals i_rd, that read port returns i_wdata in the same cycle.
REQ-030 Without LC4_REGFILE_BYPASS_EN: that read port returns the pre-write register contents. The written value appears the following cycle.
REQ-031 The bypass never applies to o_nzp, which is always the registered value.

Structure
REQ-032 Shared package lc4_pkg holds the following:
- register width (16) and register count (8);
- NZP encodings NZP_N=3'b100, NZP_Z=3'b010, NZP_P=3'b001.
REQ-033 Sub-module lc4_reg: one n-bit register with clk, rst, gwe, we, d and q, and a reset value parameter. It is instantiated 8 times for R0..R7 and once, with n=3, for NZP.
REQ-034 Read-port selection is two 8:1 n-bit multiplexers. The bypass compare, when compiled in, is a 3-bit equality per port ahead of the mux output.

Verification
REQ-035 Reset: assert rst for 1 cycle after arbitrary prior writes. Every R reads 16'h0000 and o_nzp=3'b000.
REQ-036 Write/read: write R3=16'hBEEF with gwe=1, i_rd_we=1. Next cycle, i_rs=3 and i_rt=3 both read 16'hBEEF, and R2 still reads 16'h0000.
REQ-037 gwe gating: i_rd_we=1, i_rd=5, i_wdata=16'h1234, gwe=0. R5 is unchanged, and o_nzp is unchanged when i_nzp_we=1.
REQ-038 NZP: i_nzp_we=1 with i_wdata 16'h8000, then 16'h0000, then 16'h0001. o_nzp is 100, then 010, then 001, each one cycle later.
REQ-039 Bypass: R4=16'h0001, then the same cycle writes R4=16'h00FF with i_rs=4.
- Bypass build: o_rs_data=16'h00FF in that cycle.
- Non-bypass build: o_rs_data=16'h0001 in that cycle, then 16'h00FF next cycle.
REQ-040 Reset priority: rst=1 together with a write of R1=16'h5555 and i_nzp_we=1. Afterwards R1=16'h0000 and o_nzp=3'b000.
